pwm_fade_ctrl: RTL and testbench



---
 rtl/pwm_fade_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_ctrl.sv
// PWM brightness fade controller: ramps the timer compare value up and down
// one step per PWM period ("breathing"), in single-shot or continuous mode.
// Optional macro PWM_FADE_HOLD_EN adds the hold port and a dwell at each extreme.
module pwm_fade_ctrl #(
  parameter int unsigned size   = 24,
  parameter int unsigned hold_w = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [size-1:0]   tmr_count,
  input  logic              en,
  input  logic              mode,
  input  logic [size-1:0]   level_min,
  input  logic [size-1:0]   level_max,
  input  logic [size-1:0]   step,
`ifdef PWM_FADE_HOLD_EN
  input  logic [hold_w-1:0] hold,
`endif
  output logic [size-1:0]   duty,
  output logic              busy,
  output logic              done
);

  // The hold counter needs at least one bit.
  if (hold_w == 0) begin : g_bad_hold_w
    $error("pwm_fade_ctrl: hold_w must be at least 1");
  end

`ifdef PWM_FADE_HOLD_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UP      = 3'd1,
    HOLD_HI = 3'd2,
    DOWN    = 3'd3,
    HOLD_LO = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_e;
`endif

  state_e          state_q, state_d;
  logic [size-1:0] duty_q, duty_d;
  logic [size-1:0] lmin_q, lmin_d;
  logic [size-1:0] lmax_q, lmax_d;
  logic [size-1:0] lstep_q, lstep_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
`ifdef PWM_FADE_HOLD_EN
  logic [hold_w-1:0] lhold_q, lhold_d;
  logic [hold_w-1:0] hcnt_q, hcnt_d;
`endif

  logic            tick_c;
  logic            latch_c;
  logic            lo_exit_c;
  logic [size-1:0] lmin_in_c;
  logic [size-1:0] lstep_in_c;
  logic [size:0]   sum_c;
  logic [size:0]   thr_c;

  // Period tick, parameter clamps and overflow-free ramp arithmetic.
  assign tick_c     = (tmr_count == '0);
  assign lmin_in_c  = (level_min > level_max) ? level_max : level_min;
  assign lstep_in_c = (step == '0) ? size'(1) : step;
  assign sum_c      = {1'b0, duty_q} + {1'b0, lstep_q};
  assign thr_c      = {1'b0, lmin_q} + {1'b0, lstep_q};

  // Next-state, duty and parameter-latch logic.
  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    lmin_d    = lmin_q;
    lmax_d    = lmax_q;
    lstep_d   = lstep_q;
    done_d    = 1'b0;
    latch_c   = 1'b0;
    lo_exit_c = 1'b0;
`ifdef PWM_FADE_HOLD_EN
    lhold_d   = lhold_q;
    hcnt_d    = hcnt_q;
`endif

    if ((state_q != IDLE) && !en) begin
      state_d = IDLE;
      duty_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            latch_c = 1'b1;
            duty_d  = lmin_in_c;
            state_d = UP;
          end
        end
        UP: begin
          if (tick_c) begin
            if (sum_c >= {1'b0, lmax_q}) begin
              duty_d = lmax_q;
`ifdef PWM_FADE_HOLD_EN
              hcnt_d  = lhold_q;
              state_d = HOLD_HI;
`else
              state_d = DOWN;
`endif
            end else begin
              duty_d = sum_c[size-1:0];
            end
          end
        end
`ifdef PWM_FADE_HOLD_EN
        HOLD_HI: begin
          if (tick_c) begin
            if (hcnt_q == '0) state_d = DOWN;
            else              hcnt_d  = hcnt_q - hold_w'(1);
          end
        end
        HOLD_LO: begin
          if (tick_c) begin
            if (hcnt_q == '0) lo_exit_c = 1'b1;
            else              hcnt_d    = hcnt_q - hold_w'(1);
          end
        end
`endif
        DOWN: begin
          if (tick_c) begin
            if ({1'b0, duty_q} <= thr_c) begin
              duty_d = lmin_q;
`ifdef PWM_FADE_HOLD_EN
              hcnt_d  = lhold_q;
              state_d = HOLD_LO;
`else
              lo_exit_c = 1'b1;
`endif
            end else begin
              duty_d = duty_q - lstep_q;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // End of a full cycle: pulse done, then restart or return to idle.
    if (lo_exit_c) begin
      done_d = 1'b1;
      if (mode) begin
        latch_c = 1'b1;
        state_d = UP;
      end else begin
        state_d = IDLE;
      end
    end

    if (latch_c) begin
      lmin_d  = lmin_in_c;
      lmax_d  = level_max;
      lstep_d = lstep_in_c;
`ifdef PWM_FADE_HOLD_EN
      lhold_d = hold;
`endif
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      duty_q  <= '0;
      lmin_q  <= '0;
      lmax_q  <= '0;
      lstep_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PWM_FADE_HOLD_EN
      lhold_q <= '0;
      hcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      lmin_q  <= lmin_d;
      lmax_q  <= lmax_d;
      lstep_q <= lstep_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PWM_FADE_HOLD_EN
      lhold_q <= lhold_d;
      hcnt_q  <= hcnt_d;
`endif
    end
  end

  assign duty = duty_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl: directed scenarios plus randomized
// fades compared every clock against a precomputed per-tick duty schedule.
`timescale 1ns/1ps
module tb_pwm_fade_ctrl;

  localparam int unsigned SIZE   = 8;
  localparam int unsigned HOLD_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [SIZE-1:0]   tmr_count;
  logic              en;
  logic              mode;
  logic [SIZE-1:0]   level_min;
  logic [SIZE-1:0]   level_max;
  logic [SIZE-1:0]   step;
  logic [HOLD_W-1:0] hold;
  logic [SIZE-1:0]   duty;
  logic              busy;
  logic              done;

  pwm_fade_ctrl #(.size(SIZE), .hold_w(HOLD_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .tmr_count (tmr_count),
    .en        (en),
    .mode      (mode),
    .level_min (level_min),
    .level_max (level_max),
    .step      (step),
`ifdef PWM_FADE_HOLD_EN
    .hold      (hold),
`endif
    .duty      (duty),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: a whole fade cycle is expanded into the list of duty
  // values seen after each tick, with the final entry carrying the done pulse.
  typedef struct { int unsigned duty; bit done; } entry_t;
  entry_t      sched[$];
  int unsigned m_min, m_max, m_step, m_hold;
  bit          m_active = 0;
  int unsigned e_duty   = 0;
  bit          e_busy   = 0;
  bit          e_done   = 0;
  int unsigned per      = 4;
  int unsigned ph       = 0;
  int unsigned n_done_dut = 0;

  function automatic void latch_params();
    m_max  = int'(level_max);
    m_min  = (level_min > level_max) ? int'(level_max) : int'(level_min);
    m_step = (step == 0) ? 1 : int'(step);
    m_hold = int'(hold);
  endfunction

  function automatic void build_cycle(int unsigned start);
    int unsigned d = start;
    sched.delete();
    forever begin
      if (d + m_step >= m_max) begin d = m_max; sched.push_back('{d, 1'b0}); break; end
      d = d + m_step;
      sched.push_back('{d, 1'b0});
    end
`ifdef PWM_FADE_HOLD_EN
    repeat (m_hold + 1) sched.push_back('{d, 1'b0});
`endif
    forever begin
      if (d <= m_min + m_step) begin d = m_min; sched.push_back('{d, 1'b0}); break; end
      d = d - m_step;
      sched.push_back('{d, 1'b0});
    end
`ifdef PWM_FADE_HOLD_EN
    repeat (m_hold) sched.push_back('{d, 1'b0});
    sched.push_back('{d, 1'b1});
`else
    sched[sched.size()-1].done = 1'b1;
`endif
  endfunction

  // One clock: drive tmr_count, advance the model, then check after the edge.
  task automatic cycle();
    bit     tick;
    entry_t e;
    tick      = (ph == 0);
    tmr_count = tick ? '0 : SIZE'(ph);
    ph        = (ph + 1) % per;
    e_done    = 1'b0;
    if (!m_active) begin
      if (en) begin
        latch_params();
        e_duty   = m_min;
        m_active = 1'b1;
        build_cycle(e_duty);
      end
    end else if (!en) begin
      m_active = 1'b0;
      e_duty   = 0;
    end else if (tick && sched.size() > 0) begin
      e      = sched.pop_front();
      e_duty = e.duty;
      e_done = e.done;
      if (e.done) begin
        if (mode) begin latch_params(); build_cycle(e_duty); end
        else m_active = 1'b0;
      end
    end
    e_busy = m_active;
    @(posedge clk);
    #1;
    n_done_dut += int'(done);
    chk("duty", 32'(duty), e_duty);
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
  endtask

  task automatic setup(input int unsigned mn, input int unsigned mx, input int unsigned st,
                       input int unsigned hd, input bit md, input int unsigned p);
    level_min = SIZE'(mn);
    level_max = SIZE'(mx);
    step      = SIZE'(st);
    hold      = HOLD_W'(hd);
    mode      = md;
    per       = p;
    ph        = 0;
  endtask

  // Run until the model leaves the active state, bounded by max_clk.
  task automatic run_to_idle(input string tag, input int unsigned max_clk);
    int unsigned n = 0;
    cycle();
    while (m_active && n < max_clk) begin cycle(); n++; end
    chk({tag, "_ends_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset_mid_fade();
    int unsigned n = 0;
    while (!(m_active && e_duty == 6) && n < 200) begin cycle(); n++; end
    chk("rst_reach6", 32'(duty), 32'd6);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_duty", 32'(duty), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_done", 32'(done), 32'd0);
    m_active = 1'b0; e_duty = 0; sched.delete();
    en = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    #1;
    repeat (6) cycle();
  endtask

  initial begin
    rst = 1'b0; en = 1'b0;
    setup(0, 10, 3, 2, 1'b0, 4);
    tmr_count = '0;
    @(posedge clk); #1;
    chk("reset_duty", 32'(duty), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b1;
    repeat (6) cycle();

    // Async reset in the middle of a ramp.
    en = 1'b1;
    do_reset_mid_fade();

    // Single-shot fade, tick every 4 clocks.
    n_done_dut = 0;
    setup(0, 10, 3, 2, 1'b0, 4);
    en = 1'b1;
    run_to_idle("single", 400);
    chk("single_done_cnt", n_done_dut, 32'd1);
    en = 1'b0;
    repeat (3) cycle();

    // Continuous mode: two complete cycles without going idle.
    n_done_dut = 0;
    setup(0, 10, 3, 2, 1'b1, 4);
    en = 1'b1;
    for (int i = 0; i < 800 && n_done_dut < 2; i++) cycle();
    chk("cont_done_cnt", n_done_dut, 32'd2);
    chk("cont_busy", 32'(busy), 32'd1);
    mode = 1'b0;
    run_to_idle("cont", 400);

    // Abort while ramping up at duty 6, then restart from level_min.
    en = 1'b0; cycle();
    setup(2, 40, 2, 1, 1'b0, 2);
    en = 1'b1;
    for (int i = 0; i < 100 && !(m_active && e_duty == 6); i++) cycle();
    chk("abort_at6", 32'(duty), 32'd6);
    en = 1'b0; cycle();
    en = 1'b1; cycle();
    chk("restart_min", 32'(duty), 32'd2);
    run_to_idle("restart", 400);

    // Boundaries: no wrap near full scale, step 0, inverted limits, period 0.
    en = 1'b0; cycle();
    setup(0, 255, 200, 1, 1'b0, 3); en = 1'b1; run_to_idle("wrap", 400);
    en = 1'b0; cycle();
    setup(5, 12, 0, 0, 1'b0, 2);    en = 1'b1; run_to_idle("step0", 400);
    en = 1'b0; cycle();
    setup(20, 10, 4, 1, 1'b0, 2);   en = 1'b1; run_to_idle("inverted", 400);
    en = 1'b0; cycle();
    setup(0, 10, 3, 2, 1'b0, 1);    en = 1'b1; run_to_idle("period0", 400);
    en = 1'b0; cycle();

    // Randomized fades with mid-fade input changes and occasional aborts.
    for (int r = 0; r < 25; r++) begin
      setup($urandom_range(255), $urandom_range(255),
            ($urandom_range(7) == 0) ? 0 : $urandom_range(1, 64),
            $urandom_range(3), 1'($urandom_range(1)), $urandom_range(1, 4));
      en = 1'b1;
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(9) == 0) begin
          level_min = SIZE'($urandom);
          level_max = SIZE'($urandom);
          step      = SIZE'($urandom_range(64));
          hold      = HOLD_W'($urandom_range(3));
        end
        if ($urandom_range(199) == 0) en = 1'b0;
        else if (!en) en = 1'b1;
        if (c == 250) mode = 1'b0;
        cycle();
      end
      en = 1'b0;
      cycle();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
